// File: rtl/esc_multi.sv
// N-channel frame-synchronous ESC pulse generator with arming, failsafe and enable.
// Optional SLEW_EN macro limits the per-frame width change of armed channels.
module esc_multi #(
    parameter int N              = 4,
    parameter int CMD_W          = 8,
    parameter int DIV            = 50,
    parameter int PERIOD_US      = 20000,
    parameter int MIN_US         = 1000,
    parameter int GAIN           = 4,
    parameter int MAX_US         = 2000,
    parameter int ARM_FRAMES     = 100,
    parameter int TIMEOUT_FRAMES = 25,
    parameter int CNT_W          = 15
`ifdef SLEW_EN
    ,
    parameter int SLEW_US        = 50
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*CMD_W-1:0] cmd,
    input  logic               cmd_valid,
    input  logic               enable,
    output logic [N-1:0]       esc,
    output logic               armed,
    output logic               fault,
    output logic               frame_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WW = CNT_W + 1;
    localparam logic [15:0] ARM_L = 16'(ARM_FRAMES);
    localparam logic [15:0] TO_L  = 16'(TIMEOUT_FRAMES);
    localparam logic [WW-1:0] MIN_W = WW'(MIN_US);
    localparam logic [WW-1:0] MAX_W = WW'(MAX_US);

    logic [PW-1:0]      pre;
    logic               tick;
    logic               started;
    logic               wrap;
    logic [CNT_W-1:0]   frame_cnt;
    logic [N*CMD_W-1:0] shadow;
    logic [15:0]        arm_cnt;
    logic [15:0]        arm_nxt;
    logic [15:0]        loss_cnt;
    logic [15:0]        loss_nxt;
    logic               fault_nxt;
    logic [WW-1:0]      base_w   [N];
    logic [WW-1:0]      step_w   [N];
    logic [WW-1:0]      new_w    [N];
    logic [WW-1:0]      active   [N];

    assign tick = (pre == PW'(DIV - 1));

    // The very first tick after reset opens frame 0 instead of advancing it.
    assign wrap = tick &&
                  (!started || frame_cnt == CNT_W'(PERIOD_US - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre         <= '0;
            started     <= 1'b0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + 1'b1;
            frame_start <= wrap;
            if (tick) begin
                started   <= 1'b1;
                frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (cmd_valid) begin
            shadow <= cmd;
        end
    end

    assign arm_nxt = (arm_cnt == ARM_L) ? arm_cnt : arm_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (wrap) begin
            arm_cnt <= arm_nxt;
            if (arm_nxt == ARM_L) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        loss_nxt = loss_cnt;
        if (cmd_valid) begin
            loss_nxt = '0;
        end else if (wrap && loss_cnt != TO_L) begin
            loss_nxt = loss_cnt + 16'd1;
        end
    end

    if (TIMEOUT_FRAMES == 0) begin : g_no_fs
        assign fault_nxt = 1'b0;
    end else begin : g_fs
        assign fault_nxt = (loss_nxt == TO_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            loss_cnt <= loss_nxt;
            fault    <= fault_nxt;
        end
    end

`ifdef SLEW_EN
    localparam logic [WW-1:0] SLEW_W = WW'(SLEW_US);
    logic [WW-1:0] slew_w   [N];
    logic [WW-1:0] slew_nxt [N];
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            base_w[i] = MIN_W +
                        WW'(shadow[i*CMD_W +: CMD_W]) * WW'(GAIN);
            if (base_w[i] > MAX_W) begin
                base_w[i] = MAX_W;
            end
`ifdef SLEW_EN
            if (base_w[i] > slew_w[i] + SLEW_W) begin
                step_w[i] = slew_w[i] + SLEW_W;
            end else if (base_w[i] + SLEW_W < slew_w[i]) begin
                step_w[i] = slew_w[i] - SLEW_W;
            end else begin
                step_w[i] = base_w[i];
            end
            slew_nxt[i] = (enable && armed && !fault_nxt) ?
                          step_w[i] : MIN_W;
`else
            step_w[i] = base_w[i];
`endif
            if (!enable) begin
                new_w[i] = '0;
            end else if (!armed || fault_nxt) begin
                new_w[i] = MIN_W;
            end else begin
                new_w[i] = step_w[i];
            end
        end
    end

    // Widths are latched once per frame so mid-frame changes never cut a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                active[i] <= '0;
`ifdef SLEW_EN
                slew_w[i] <= '0;
`endif
            end
        end else if (wrap) begin
            for (int i = 0; i < N; i++) begin
                active[i] <= new_w[i];
`ifdef SLEW_EN
                slew_w[i] <= slew_nxt[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            esc <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                esc[i] <= ({1'b0, frame_cnt} < active[i]);
            end
        end
    end

endmodule

// File: tb/tb_esc_multi.sv
// Bench for esc_multi: directed and random frames measured against a
// frame-level model of arming, failsafe, enable and width clamping.
module tb_esc_multi;

    localparam int N     = 2;
    localparam int CMD_W = 8;
    localparam int DIV   = 2;
    localparam int P     = 100;
    localparam int MINU  = 10;
    localparam int GAIN  = 1;
    localparam int MAXU  = 60;
    localparam int ARM   = 2;
    localparam int TO    = 3;
    localparam int FCLK  = P * DIV;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N*CMD_W-1:0] cmd = '0;
    logic               cmd_valid = 1'b0;
    logic               enable = 1'b1;
    logic [N-1:0]       esc;
    logic               armed;
    logic               fault;
    logic               frame_start;

    int checks = 0;
    int errors = 0;

    int m_sh[N];
    int m_frames;
    int m_loss;
    bit m_fault;
    bit m_en;
    int ew[N];

    esc_multi #(
        .N(N), .CMD_W(CMD_W), .DIV(DIV), .PERIOD_US(P),
        .MIN_US(MINU), .GAIN(GAIN), .MAX_US(MAXU),
        .ARM_FRAMES(ARM), .TIMEOUT_FRAMES(TO), .CNT_W(15)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid),
        .enable(enable), .esc(esc), .armed(armed), .fault(fault),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_sh[i] = 0;
        m_frames = 0;
        m_loss   = 0;
        m_fault  = 0;
    endfunction

    // Frame start: decide this frame's widths from the state before it.
    function automatic void model_frame();
        bit was_armed;
        was_armed = (m_frames >= ARM);
        m_frames++;
        if (m_loss < TO) m_loss++;
        m_fault = (m_loss >= TO);
        for (int i = 0; i < N; i++) begin
            if (!m_en) ew[i] = 0;
            else if (!was_armed || m_fault) ew[i] = MINU;
            else begin
                ew[i] = MINU + m_sh[i] * GAIN;
                if (ew[i] > MAXU) ew[i] = MAXU;
            end
        end
    endfunction

    task automatic wait_fs(input int bound);
        int n = 0;
        while (frame_start !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("fs_wait", frame_start, 1);
    endtask

    // Entered at the negedge where frame_start is high; measures one frame.
    task automatic run_frame(input int st, input logic [15:0] cv,
                             input int ea, input bit ev);
        int cnt[N];
        int runs[N];
        logic [N-1:0] prev;
        model_frame();
        chk("armed", armed, 32'(m_frames >= ARM));
        chk("fault", fault, 32'(m_fault));
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            runs[i] = 0;
        end
        prev = '0;
        for (int c = 0; c < FCLK; c++) begin
            for (int i = 0; i < N; i++) begin
                if (esc[i] === 1'b1) begin
                    cnt[i]++;
                    if (!prev[i]) runs[i]++;
                end
            end
            prev = esc;
            if (c == 1) chk("fs_low", frame_start, 0);
            if (st >= 0 && c == st) begin
                cmd = cv;
                cmd_valid = 1'b1;
            end
            if (st >= 0 && c == st + 1) begin
                cmd_valid = 1'b0;
                m_sh[0] = int'(cv[7:0]);
                m_sh[1] = int'(cv[15:8]);
                m_loss = 0;
                m_fault = 0;
                chk("fault_clr", fault, 0);
            end
            if (c == ea) begin
                enable = ev;
                m_en = ev;
            end
            @(negedge clk);
        end
        chk("width0", cnt[0], ew[0] * DIV);
        chk("width1", cnt[1], ew[1] * DIV);
        chk("runs0", runs[0], 32'(ew[0] > 0));
        chk("runs1", runs[1], 32'(ew[1] > 0));
        chk("period", frame_start, 1);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        model_reset();
        for (int k = 1; k < DIV; k++) begin
            @(negedge clk);
            chk("fs_absent", frame_start, 0);
        end
        @(negedge clk);
        chk("fs_first", frame_start, 1);
        wait_fs(4 * DIV);
    endtask

    initial begin
        logic [15:0] cv;
        logic [N-1:0] exp_esc;
        int st;
        int ea;
        bit ev;
        m_en = 1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_esc", esc, 0);
        chk("rst_armed", armed, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fs", frame_start, 0);
        release_rst();

        run_frame(30, {8'd40, 8'd5}, -1, 1'b1);
        run_frame(30, {8'd40, 8'd5}, -1, 1'b1);
        run_frame(30, {8'd40, 8'd200}, -1, 1'b1);
        run_frame(30, {8'd40, 8'd5}, -1, 1'b1);
        run_frame(24, {8'd40, 8'd40}, -1, 1'b1);
        run_frame(-1, 16'd0, -1, 1'b1);
        run_frame(-1, 16'd0, -1, 1'b1);
        run_frame(-1, 16'd0, -1, 1'b1);
        run_frame(40, {8'd40, 8'd40}, -1, 1'b1);
        run_frame(30, {8'd40, 8'd40}, 10, 1'b0);
        run_frame(30, {8'd40, 8'd40}, 150, 1'b1);
        run_frame(30, {8'd40, 8'd40}, -1, 1'b1);

        for (int f = 0; f < 10; f++) begin
            cv = 16'($urandom);
            st = ($urandom_range(0, 3) == 0) ? -1 :
                 int'($urandom_range(2, FCLK - 3));
            ea = int'($urandom_range(1, FCLK - 1));
            ev = ($urandom_range(0, 3) != 0);
            run_frame(st, cv, ea, ev);
        end
        run_frame(30, {8'd20, 8'd10}, 5, 1'b1);
        run_frame(30, {8'd20, 8'd10}, 5, 1'b1);

        model_frame();
        repeat (16) @(negedge clk);
        for (int i = 0; i < N; i++) exp_esc[i] = (ew[i] > 7);
        chk("esc_pre_rst", esc, exp_esc);
        rst = 1'b1;
        #1;
        chk("mid_rst_esc", esc, 0);
        chk("mid_rst_armed", armed, 0);
        chk("mid_rst_fs", frame_start, 0);
        repeat (3) @(negedge clk);
        release_rst();
        run_frame(30, {8'd40, 8'd5}, -1, 1'b1);
        run_frame(30, {8'd40, 8'd5}, -1, 1'b1);
        run_frame(30, {8'd40, 8'd5}, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/esc_multi.md
Name: esc_multi

Overview:
Parametrised N-channel ESC pulse generator that supersedes the single-channel esc block.
- Derives its own 1 µs tick from the system clock, so no separate 1 MHz clock module is needed.
- Produces frame-synchronous, glitch-free servo-style pulses per channel.
- Adds arming, a command-loss failsafe and an output enable.
- Sits between the command source (sawtooth, SPI or serial decoder) and the esc_out pins.

Parameters:
N, 4, number of ESC channels
CMD_W, 8, bits per channel command
DIV, 50, clk cycles per 1 µs tick (50 MHz clk)
PERIOD_US, 20000, frame length in ticks (50 Hz); 2500 gives 400 Hz
MIN_US, 1000, pulse width for cmd=0, and the safe/disarmed pulse width
GAIN, 4, ticks added per command LSB
MAX_US, 2000, upper clamp on pulse width
ARM_FRAMES, 100, frames of MIN_US pulses after reset before commands are honoured
TIMEOUT_FRAMES, 25, frames without cmd_valid before failsafe; 0 disables the failsafe
CNT_W, 15, frame counter width; must satisfy 2^CNT_W > PERIOD_US

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd  in  N*CMD_W  packed commands, channel i at [i*CMD_W +: CMD_W]
cmd_valid  in  1  one-cycle strobe; captures all of cmd into the shadow register
enable  in  1  output enable, sampled at frame start
esc  out  N  pulse outputs, registered
armed  out  1  high once the arming period has completed
fault  out  1  high while the failsafe is active
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (async, rst=1):
  - esc=0, armed=0, fault=0, frame_start=0.
  - shadow=0, prescaler=0, frame_cnt=0.
  - arm_cnt=0, loss_cnt=0, active widths=0.
- Prescaler:
  - Counts 0..DIV-1.
  - tick asserts for the one clk in which prescaler==DIV-1.
  - The first tick occurs DIV clks after rst falls.
- Frame counter:
  - Advances on each tick, 0..PERIOD_US-1, then wraps to 0.
  - frame_start is registered: it is high in the clk after a tick that leaves frame_cnt at 0.
  - The first tick after reset counts as a frame start.
- Shadow register:
  - Loaded from cmd on the cycle cmd_valid=1.
  - If cmd_valid and frame_start fall in the same cycle, the frame latches the old shadow value; the new value takes effect next frame.
- Width computation at each frame start, per channel:
  - w = MIN_US + shadow_i*GAIN, using CNT_W+1-bit arithmetic with no overflow.
  - w is then clamped to MAX_US.
  - w is replaced by MIN_US if armed=0 or fault=1.
  - w is replaced by 0 if the sampled enable=0.
  - The result is held in the active register for the whole frame, so mid-frame command changes cannot produce runt or stretched pulses.
- Output: esc[i] <= (frame_cnt < active_i), registered. This gives 1-clk latency from the counter, so the pulse width is exactly w ticks.
- Arming:
  - arm_cnt increments at each frame start, saturating.
  - armed rises when arm_cnt reaches ARM_FRAMES.
  - The first frame using commands is the one after armed rises.
  - armed clears only on reset; enable does not affect arming.
- Failsafe:
  - loss_cnt is cleared by cmd_valid and otherwise increments at each frame start, saturating.
  - fault sets when loss_cnt reaches TIMEOUT_FRAMES.
  - fault clears on the next cmd_valid; the new command is honoured from the following frame start.
  - With TIMEOUT_FRAMES=0, fault is tied to 0.
- Enable: a change of enable mid-frame has no effect until the next frame start.
- Reset mid-frame: esc drops to 0 immediately (asynchronous), and arming restarts.

Optional Feature:
SLEW_EN
- Defined:
  - Adds parameter SLEW_US (default 50).
  - Each channel's armed, non-fault width may change by at most ±SLEW_US per frame toward its target.
  - The jump to MIN_US on fault or disarm, and to 0 on disable, is immediate and also reinitialises the slew state.
- Undefined: the target width is applied directly each frame.

Test Plan:
Use test parameters DIV=2, PERIOD_US=100, MIN_US=10, GAIN=1, MAX_US=60, ARM_FRAMES=2, TIMEOUT_FRAMES=3, N=2 throughout.
1. Reset release, enable=1, cmd={8'd40, 8'd5} with one cmd_valid each frame -> frames 1-2: both esc pulses 10 ticks (20 clk), armed=0; armed=1 after the 2nd frame_start; frame 3: ch0=15 ticks, ch1=50 ticks; period always 200 clk.
2. Armed, cmd ch0=200 -> pulse clamped to 60 ticks (120 clk).
3. Armed, change cmd from 5 to 40 at frame_cnt=12 mid-frame -> current pulse stays 15 ticks; next frame 50 ticks; no runt pulse.
4. Armed, stop cmd_valid -> fault=1 at the 3rd frame start without a strobe, pulses become 10 ticks; one cmd_valid with 40 -> fault=0 immediately, 50-tick pulse from the next frame.
5. enable drops at frame_cnt=5 -> current frame unaffected; next frame esc=0 throughout; re-enable -> pulses resume at the next frame start, armed stays 1.
6. Assert rst at frame_cnt=8 while esc=1 -> esc=0 in the same cycle, armed=0, frame_start absent until DIV clks after release.
